// File: rtl/free_list.sv
// Physical-register free list: hands out up to N_WAY tags per cycle, reclaims retired
// old mappings, and rewinds the speculative head to the architectural head on a flush.
module free_list #(
    parameter int N_WAY      = 2,
    parameter int N_PHYS_REG = 64,
    parameter int N_ARCH_REG = 32,
    parameter int CDB_BITS   = $clog2(N_PHYS_REG),
    parameter int FL_DEPTH   = N_PHYS_REG - N_ARCH_REG
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [N_WAY-1:0]                 alloc_req,
    output logic [N_WAY-1:0][CDB_BITS-1:0]   alloc_tag,
    output logic [N_WAY-1:0]                 alloc_valid,
    output logic [$clog2(N_WAY):0]           free_num,
    input  logic [N_WAY-1:0]                 retire_valid,
    input  logic [N_WAY-1:0][CDB_BITS-1:0]   retire_tag,
    input  logic [N_WAY-1:0][CDB_BITS-1:0]   retire_told,
    input  logic                             branch_haz
);

    localparam int PW = $clog2(FL_DEPTH);
    localparam int CW = $clog2(FL_DEPTH + 1);
    localparam int FW = $clog2(N_WAY) + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [CDB_BITS-1:0] mem [FL_DEPTH];
    ptr_t                spec_head;
    ptr_t                arch_head;
    ptr_t                tail;
    cnt_t                spec_count;

    cnt_t                g_tot;
    cnt_t                f_tot;
    logic [N_WAY-1:0]    wr_en;
    ptr_t [N_WAY-1:0]    wr_idx;

    // Grants are packed onto consecutive entries starting at spec_head.
    always_comb begin
        g_tot       = '0;
        alloc_valid = '0;
        alloc_tag   = '0;
        for (int i = 0; i < N_WAY; i++) begin
            if (alloc_req[i] && !branch_haz && (g_tot < spec_count)) begin
                alloc_valid[i] = 1'b1;
                alloc_tag[i]   = mem[spec_head + g_tot[PW-1:0]];
                g_tot          = g_tot + cnt_t'(1);
            end
        end
    end

    always_comb begin
        f_tot  = '0;
        wr_en  = '0;
        wr_idx = '0;
        for (int i = 0; i < N_WAY; i++) begin
            if (retire_valid[i] && (retire_tag[i] != '0)) begin
                wr_en[i]  = 1'b1;
                wr_idx[i] = tail + f_tot[PW-1:0];
                f_tot     = f_tot + cnt_t'(1);
            end
        end
    end

    assign free_num = (spec_count >= cnt_t'(N_WAY)) ? FW'(N_WAY) : FW'(spec_count);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                mem[i] <= CDB_BITS'(N_ARCH_REG + i);
            end
            spec_head  <= '0;
            arch_head  <= '0;
            tail       <= '0;
            spec_count <= cnt_t'(FL_DEPTH);
        end else begin
            for (int i = 0; i < N_WAY; i++) begin
                if (wr_en[i]) begin
                    mem[wr_idx[i]] <= retire_told[i];
                end
            end
            tail      <= tail + f_tot[PW-1:0];
            arch_head <= arch_head + f_tot[PW-1:0];
            // Squashed tags sit between arch_head and spec_head, so rewinding reclaims them.
            if (branch_haz) begin
                spec_head  <= arch_head + f_tot[PW-1:0];
                spec_count <= cnt_t'(FL_DEPTH);
            end else begin
                spec_head  <= spec_head + g_tot[PW-1:0];
                spec_count <= spec_count - g_tot + f_tot;
            end
        end
    end

    // arch_head..tail always spans the whole list, which with wrapping pointers means equality.
    a_arch_span_full: assert property (@(posedge clock) disable iff (reset)
        tail == arch_head);

    a_count_range: assert property (@(posedge clock) disable iff (reset)
        spec_count <= cnt_t'(FL_DEPTH));

    a_count_matches_ptrs: assert property (@(posedge clock) disable iff (reset)
        spec_count[PW-1:0] == ptr_t'(tail - spec_head));

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed scenarios plus randomized traffic against a queue-based model.
module tb_free_list;

    logic             clock = 1'b0;
    logic             reset;
    logic [1:0]       alloc_req;
    logic [1:0][5:0]  alloc_tag;
    logic [1:0]       alloc_valid;
    logic [1:0]       free_num;
    logic [1:0]       retire_valid;
    logic [1:0][5:0]  retire_tag;
    logic [1:0][5:0]  retire_told;
    logic             branch_haz;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    free_list dut (
        .clock       (clock),
        .reset       (reset),
        .alloc_req   (alloc_req),
        .alloc_tag   (alloc_tag),
        .alloc_valid (alloc_valid),
        .free_num    (free_num),
        .retire_valid(retire_valid),
        .retire_tag  (retire_tag),
        .retire_told (retire_told),
        .branch_haz  (branch_haz)
    );

    task automatic drive(input logic [1:0] req, input logic [1:0] rv,
                         input logic [5:0] rt0, input logic [5:0] ro0,
                         input logic [5:0] rt1, input logic [5:0] ro1, input logic bh);
        alloc_req      = req;
        retire_valid   = rv;
        retire_tag[0]  = rt0;
        retire_told[0] = ro0;
        retire_tag[1]  = rt1;
        retire_told[1] = ro1;
        branch_haz     = bh;
        #1;
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        drive(2'b00, 2'b00, 0, 0, 0, 0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(2'b00, 2'b00, 0, 0, 0, 0, 1'b0);
        n_checks++;
        if (alloc_valid !== 2'b00 || alloc_tag !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_alloc: got valid=%b tag=%h, expected valid=00 tag=000", alloc_valid, alloc_tag);
        end
        n_checks++;
        if (free_num !== 2'd2) begin
            n_fail++;
            $display("FAIL reset_free_num: got %0d, expected 2", free_num);
        end
        n_checks++;
        if (dut.spec_count !== 6'd32) begin
            n_fail++;
            $display("FAIL reset_spec_count: got %0d, expected 32", dut.spec_count);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_alloc_basic();
        drive(2'b11, 2'b00, 0, 0, 0, 0, 1'b0);
        n_checks++;
        if (alloc_valid !== 2'b11 || alloc_tag !== {6'd33, 6'd32}) begin
            n_fail++;
            $display("FAIL alloc_first: got valid=%b tags=%0d,%0d, expected 11 32,33",
                     alloc_valid, alloc_tag[0], alloc_tag[1]);
        end
        step();
        drive(2'b11, 2'b00, 0, 0, 0, 0, 1'b0);
        n_checks++;
        if (alloc_valid !== 2'b11 || alloc_tag !== {6'd35, 6'd34}) begin
            n_fail++;
            $display("FAIL alloc_second: got valid=%b tags=%0d,%0d, expected 11 34,35",
                     alloc_valid, alloc_tag[0], alloc_tag[1]);
        end
        step();
        drive(2'b00, 2'b00, 0, 0, 0, 0, 1'b0);
        n_checks++;
        if (dut.spec_count !== 6'd28) begin
            n_fail++;
            $display("FAIL alloc_count: got %0d, expected 28", dut.spec_count);
        end
    endtask

    // Continues from test_alloc_basic: drains the list, then refills one entry.
    task automatic test_empty();
        for (int k = 0; k < 14; k++) begin
            drive(2'b11, 2'b00, 0, 0, 0, 0, 1'b0);
            n_checks++;
            if (alloc_tag !== {6'(37 + 2 * k), 6'(36 + 2 * k)}) begin
                n_fail++;
                $display("FAIL drain_tags[%0d]: got %0d,%0d, expected %0d,%0d",
                         k, alloc_tag[0], alloc_tag[1], 36 + 2 * k, 37 + 2 * k);
            end
            step();
        end
        drive(2'b00, 2'b00, 0, 0, 0, 0, 1'b0);
        n_checks++;
        if (free_num !== 2'd0) begin
            n_fail++;
            $display("FAIL empty_free_num: got %0d, expected 0", free_num);
        end
        drive(2'b11, 2'b00, 0, 0, 0, 0, 1'b0);
        n_checks++;
        if (alloc_valid !== 2'b00 || alloc_tag !== 12'h000) begin
            n_fail++;
            $display("FAIL empty_req: got valid=%b tag=%h, expected 00 000", alloc_valid, alloc_tag);
        end
        step();
        drive(2'b01, 2'b01, 6'd32, 6'd5, 0, 0, 1'b0);
        n_checks++;
        if (alloc_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL empty_no_bypass: got valid=%b, expected 00", alloc_valid);
        end
        step();
        drive(2'b01, 2'b00, 0, 0, 0, 0, 1'b0);
        n_checks++;
        if (alloc_valid !== 2'b01 || alloc_tag[0] !== 6'd5 || free_num !== 2'd1) begin
            n_fail++;
            $display("FAIL refill_grant: got valid=%b tag=%0d free=%0d, expected 01 5 1",
                     alloc_valid, alloc_tag[0], free_num);
        end
        step();
        drive(2'b00, 2'b00, 0, 0, 0, 0, 1'b0);
        n_checks++;
        if (free_num !== 2'd0) begin
            n_fail++;
            $display("FAIL refill_drained: got %0d, expected 0", free_num);
        end
    endtask

    task automatic test_branch();
        pulse_reset();
        drive(2'b11, 2'b00, 0, 0, 0, 0, 1'b0);
        step();
        drive(2'b11, 2'b00, 0, 0, 0, 0, 1'b0);
        step();
        drive(2'b00, 2'b01, 6'd32, 6'd7, 0, 0, 1'b0);
        step();
        drive(2'b11, 2'b01, 6'd33, 6'd9, 0, 0, 1'b1);
        n_checks++;
        if (alloc_valid !== 2'b00 || alloc_tag !== 12'h000) begin
            n_fail++;
            $display("FAIL branch_suppress: got valid=%b tag=%h, expected 00 000", alloc_valid, alloc_tag);
        end
        step();
        drive(2'b00, 2'b00, 0, 0, 0, 0, 1'b0);
        n_checks++;
        if (dut.spec_count !== 6'd32 || free_num !== 2'd2) begin
            n_fail++;
            $display("FAIL branch_recover: got count=%0d free=%0d, expected 32 2", dut.spec_count, free_num);
        end
        drive(2'b11, 2'b00, 0, 0, 0, 0, 1'b0);
        n_checks++;
        if (alloc_tag !== {6'd35, 6'd34}) begin
            n_fail++;
            $display("FAIL branch_rewind_tags: got %0d,%0d, expected 34,35", alloc_tag[0], alloc_tag[1]);
        end
        step();
        repeat (14) begin
            drive(2'b11, 2'b00, 0, 0, 0, 0, 1'b0);
            step();
        end
        drive(2'b11, 2'b00, 0, 0, 0, 0, 1'b0);
        n_checks++;
        if (alloc_valid !== 2'b11 || alloc_tag !== {6'd9, 6'd7}) begin
            n_fail++;
            $display("FAIL branch_wrap_tags: got valid=%b tags=%0d,%0d, expected 11 7,9",
                     alloc_valid, alloc_tag[0], alloc_tag[1]);
        end
        step();
    endtask

    task automatic test_retire_zero();
        pulse_reset();
        drive(2'b11, 2'b00, 0, 0, 0, 0, 1'b0);
        step();
        drive(2'b00, 2'b11, 6'd0, 6'd5, 6'd0, 6'd6, 1'b0);
        step();
        drive(2'b00, 2'b00, 0, 0, 0, 0, 1'b0);
        n_checks++;
        if (dut.tail !== 5'd0 || dut.arch_head !== 5'd0 || dut.spec_count !== 6'd30) begin
            n_fail++;
            $display("FAIL retire_zero: got tail=%0d arch=%0d count=%0d, expected 0 0 30",
                     dut.tail, dut.arch_head, dut.spec_count);
        end
    endtask

    task automatic test_async_reset();
        pulse_reset();
        repeat (5) begin
            drive(2'b11, 2'b00, 0, 0, 0, 0, 1'b0);
            step();
        end
        drive(2'b00, 2'b00, 0, 0, 0, 0, 1'b0);
        reset = 1'b1;
        #1;
        n_checks++;
        if (alloc_valid !== 2'b00 || alloc_tag !== 12'h000 || free_num !== 2'd2 ||
            dut.spec_count !== 6'd32 || dut.spec_head !== 5'd0) begin
            n_fail++;
            $display("FAIL async_reset: got valid=%b tag=%h free=%0d count=%0d head=%0d, expected 00 000 2 32 0",
                     alloc_valid, alloc_tag, free_num, dut.spec_count, dut.spec_head);
        end
        @(negedge clock);
        reset = 1'b0;
        drive(2'b01, 2'b00, 0, 0, 0, 0, 1'b0);
        n_checks++;
        if (alloc_valid !== 2'b01 || alloc_tag[0] !== 6'd32) begin
            n_fail++;
            $display("FAIL async_reset_first: got valid=%b tag=%0d, expected 01 32", alloc_valid, alloc_tag[0]);
        end
        step();
    endtask

    // Model: spec_q holds allocatable tags in order, arch_q the committed free list.
    task automatic test_random();
        int         spec_q[$];
        int         arch_q[$];
        int         g;
        int         budget;
        logic [1:0] req;
        logic [1:0] rv;
        logic [5:0] rt [2];
        logic [5:0] ro [2];
        logic       bh;
        logic [1:0]      exp_valid;
        logic [1:0][5:0] exp_tag;
        logic [1:0]      exp_free;

        pulse_reset();
        for (int t = 32; t < 64; t++) begin
            spec_q.push_back(t);
            arch_q.push_back(t);
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            req    = 2'($urandom);
            rv     = 2'($urandom);
            bh     = ($urandom_range(15) == 0);
            budget = 32 - spec_q.size();
            for (int i = 0; i < 2; i++) begin
                rt[i] = ($urandom_range(3) == 0) ? 6'd0 : 6'($urandom_range(63, 1));
                ro[i] = 6'($urandom_range(63, 1));
                if (rv[i] && rt[i] != 6'd0) begin
                    if (budget > 0) budget--;
                    else rt[i] = 6'd0;
                end
            end
            drive(req, rv, rt[0], ro[0], rt[1], ro[1], bh);

            g         = 0;
            exp_valid = '0;
            exp_tag   = '0;
            for (int i = 0; i < 2; i++) begin
                if (req[i] && !bh && g < spec_q.size()) begin
                    exp_valid[i] = 1'b1;
                    exp_tag[i]   = 6'(spec_q[g]);
                    g++;
                end
            end
            exp_free = (spec_q.size() >= 2) ? 2'd2 : 2'(spec_q.size());

            n_checks++;
            if (alloc_valid !== exp_valid || alloc_tag !== exp_tag) begin
                n_fail++;
                $display("FAIL rand_alloc[%0d]: got valid=%b tags=%0d,%0d, expected valid=%b tags=%0d,%0d",
                         cyc, alloc_valid, alloc_tag[0], alloc_tag[1], exp_valid, exp_tag[0], exp_tag[1]);
            end
            n_checks++;
            if (free_num !== exp_free || dut.spec_count !== 6'(spec_q.size())) begin
                n_fail++;
                $display("FAIL rand_count[%0d]: got free=%0d count=%0d, expected free=%0d count=%0d",
                         cyc, free_num, dut.spec_count, exp_free, spec_q.size());
            end

            repeat (g) void'(spec_q.pop_front());
            for (int i = 0; i < 2; i++) begin
                if (rv[i] && rt[i] != 6'd0) begin
                    spec_q.push_back(int'(ro[i]));
                    arch_q.push_back(int'(ro[i]));
                    void'(arch_q.pop_front());
                end
            end
            if (bh) spec_q = arch_q;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_alloc_basic();
        test_empty();
        test_branch();
        test_retire_zero();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
